// File: rtl/jtexterm_comm_arb.sv
// jtexterm_comm_arb: arbiter that serialises main-CPU and sub-CPU accesses
// onto one single-port communication RAM (clk24 domain).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   main_req/we/addr/dout  main CPU request (level, held until main_ack)
//   main_din, main_ack     main read data (registered) and done pulse
//   sub_*                  same set for the sub (sound) CPU
//   ram_addr/din/we        registered RAM port controls
//   ram_q                  RAM read data, one cycle after ram_addr
//   grant                  {sub,main} one-hot owner of the access in flight
//
// Build option: define JTEXTERM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise the main CPU has fixed priority.
module jtexterm_comm_arb #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          main_req,
  input  logic          main_we,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_dout,
  output logic [DW-1:0] main_din,
  output logic          main_ack,
  input  logic          sub_req,
  input  logic          sub_we,
  input  logic [AW-1:0] sub_addr,
  input  logic [DW-1:0] sub_dout,
  output logic [DW-1:0] sub_din,
  output logic          sub_ack,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q,
  output logic [1:0]    grant
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          last_sub, last_sub_nxt;   // 1: sub owned the last access
  logic          acc_we, acc_we_nxt;       // access in flight is a write
  logic          pick_sub;
  logic [AW-1:0] ram_addr_nxt;
  logic [DW-1:0] ram_din_nxt;
  logic          ram_we_nxt;
  logic [1:0]    grant_nxt;
  logic          main_ack_nxt, sub_ack_nxt;
  logic [DW-1:0] main_din_nxt, sub_din_nxt;

  // Winner selection, only meaningful while idle
`ifdef JTEXTERM_ARB_RR_EN
  assign pick_sub = sub_req && (!main_req || !last_sub);
`else
  assign pick_sub = sub_req && !main_req;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_nxt    = state;
    last_sub_nxt = last_sub;
    acc_we_nxt   = acc_we;
    ram_addr_nxt = ram_addr;
    ram_din_nxt  = ram_din;
    ram_we_nxt   = 1'b0;
    grant_nxt    = grant;
    main_ack_nxt = 1'b0;
    sub_ack_nxt  = 1'b0;
    main_din_nxt = main_din;
    sub_din_nxt  = sub_din;
    case (state)
      ST_IDLE: begin
        grant_nxt = 2'b00;
        if (main_req || sub_req) begin
          ram_addr_nxt = pick_sub ? sub_addr : main_addr;
          ram_din_nxt  = pick_sub ? sub_dout : main_dout;
          ram_we_nxt   = pick_sub ? sub_we   : main_we;
          acc_we_nxt   = pick_sub ? sub_we   : main_we;
          grant_nxt    = pick_sub ? 2'b10    : 2'b01;
          state_nxt    = ST_ACC;
        end
      end
      ST_ACC: begin
        // Ack is registered, so it is raised on entry to ACK
        main_ack_nxt = grant[0];
        sub_ack_nxt  = grant[1];
        state_nxt    = ST_ACK;
      end
      ST_ACK: begin
        if (!acc_we) begin
          if (grant[1]) sub_din_nxt  = ram_q;
          else          main_din_nxt = ram_q;
        end
        last_sub_nxt = grant[1];
        grant_nxt    = 2'b00;
        state_nxt    = ST_IDLE;
      end
      default: begin
        grant_nxt = 2'b00;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last_sub <= 1'b1;
      acc_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      grant    <= 2'b00;
      main_ack <= 1'b0;
      sub_ack  <= 1'b0;
      main_din <= '0;
      sub_din  <= '0;
    end else begin
      state    <= state_nxt;
      last_sub <= last_sub_nxt;
      acc_we   <= acc_we_nxt;
      ram_addr <= ram_addr_nxt;
      ram_din  <= ram_din_nxt;
      ram_we   <= ram_we_nxt;
      grant    <= grant_nxt;
      main_ack <= main_ack_nxt;
      sub_ack  <= sub_ack_nxt;
      main_din <= main_din_nxt;
      sub_din  <= sub_din_nxt;
    end
  end

endmodule
